// File: rtl/sram_stream_reader.sv
// Streams LEN consecutive SRAM words (base wraps modulo RAM_DEPTH) as a valid/ready stream with LAST.
// Define SRAM_STREAM_PERF_EN to add stall_cnt (busy cycles with m_valid & !m_ready).
module sram_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk0,
  input  logic                  rst0,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   len,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_csb0,
  output logic                  mem_web0,
  output logic [ADDR_WIDTH-1:0] mem_addr0,
  input  logic [DATA_WIDTH-1:0] mem_dout0,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last
`ifdef SRAM_STREAM_PERF_EN
  ,
  output logic [15:0]           stall_cnt
`endif
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_WIDTH:0]   LEN_ONE  = 1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [PTR_W-1:0]      PTR_ONE  = 1;
  localparam logic [CNT_W-1:0]      CNT_ONE  = 1;
  localparam logic [CNT_W:0]        DEPTH_W  = (CNT_W+1)'(FIFO_DEPTH);

  logic [1:0]            state_q, state_d;
  logic [ADDR_WIDTH:0]   len_q, len_d;
  logic [ADDR_WIDTH:0]   issue_cnt_q, issue_cnt_d;
  logic [ADDR_WIDTH:0]   accept_cnt_q, accept_cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  csb_q, csb_d;
  logic                  inflight_q, inflight_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] fifo_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_d [FIFO_DEPTH];

  logic            start_ok, issue, push, pop, last_pop;
  logic [CNT_W:0]  pending;

  assign m_valid   = (count_q != '0);
  assign m_data    = m_valid ? fifo_q[rd_ptr_q] : '0;
  assign m_last    = m_valid && (accept_cnt_q == len_q - LEN_ONE);
  assign busy      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign mem_csb0  = csb_q;
  assign mem_web0  = 1'b1;
  assign mem_addr0 = addr_q;

  // Outstanding words = FIFO contents + read being captured + read on the SRAM pins.
  always_comb begin
    start_ok = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    pending  = {1'b0, count_q} + {{CNT_W{1'b0}}, inflight_q} + {{CNT_W{1'b0}}, ~csb_q};
    issue    = (state_q == S_ISSUE) && (issue_cnt_q != len_q) && (pending < DEPTH_W);
    push     = inflight_q;
    pop      = m_valid && m_ready;
    last_pop = pop && (accept_cnt_q == len_q - LEN_ONE);
  end

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    issue_cnt_d  = issue_cnt_q;
    accept_cnt_d = accept_cnt_q;
    addr_d       = addr_q;
    csb_d        = 1'b1;
    inflight_d   = ~csb_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    fifo_d       = fifo_q;

    if (pop) begin
      accept_cnt_d = accept_cnt_q + LEN_ONE;
    end

    case (state_q)
      S_IDLE, S_DONE: begin
        if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
        if (start_ok) begin
          len_d        = len;
          accept_cnt_d = '0;
          if (len == '0) begin
            state_d = S_DONE;
          end else begin
            state_d     = S_ISSUE;
            csb_d       = 1'b0;
            addr_d      = base_addr;
            issue_cnt_d = LEN_ONE;
          end
        end
      end
      S_ISSUE: begin
        if (issue) begin
          csb_d       = 1'b0;
          addr_d      = addr_q + ADDR_ONE;
          issue_cnt_d = issue_cnt_q + LEN_ONE;
        end
        if (issue_cnt_d == len_q) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (last_pop) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (push) begin
      fifo_d[wr_ptr_q] = mem_dout0;
      wr_ptr_d         = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      issue_cnt_q  <= '0;
      accept_cnt_q <= '0;
      addr_q       <= '0;
      csb_q        <= 1'b1;
      inflight_q   <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      issue_cnt_q  <= issue_cnt_d;
      accept_cnt_q <= accept_cnt_d;
      addr_q       <= addr_d;
      csb_q        <= csb_d;
      inflight_q   <= inflight_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      fifo_q       <= fifo_d;
    end
  end

`ifdef SRAM_STREAM_PERF_EN
  logic [15:0] stall_q, stall_d;

  assign stall_cnt = stall_q;

  always_comb begin
    stall_d = stall_q;
    if (start_ok) begin
      stall_d = '0;
    end else if (busy && m_valid && !m_ready && (stall_q != 16'hFFFF)) begin
      stall_d = stall_q + 16'd1;
    end
  end

  always_ff @(posedge clk0 or posedge rst0) begin
    if (rst0) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end
`endif

endmodule

// File: tb/tb_sram_stream_reader.sv
// Scoreboard bench for sram_stream_reader: expected words queued at start, compared at each handshake.
`timescale 1ns/1ps
module tb_sram_stream_reader;
  localparam int DW    = 8;
  localparam int AW    = 6;
  localparam int DEPTH = 64;

  logic          clk0 = 1'b0;
  logic          rst0 = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   len = '0;
  logic          busy, done, mem_csb0, mem_web0;
  logic [AW-1:0] mem_addr0;
  logic [DW-1:0] mem_dout0 = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [DW-1:0] m_data;
  logic          m_last;
`ifdef SRAM_STREAM_PERF_EN
  logic [15:0]   stall_cnt;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  logic [DW-1:0] mem [DEPTH];
  logic [DW:0]   exp_q [$];
  logic [DW:0]   e;
  int issued = 0, accepted = 0;
  int first_csb = -1, first_vld = -1, first_hs = -1, last_hs = -1;
  logic          hold_chk = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic          prev_last = 1'b0;
  logic [19:0]   rst_vec = {1'b0, 1'b0, 1'b1, 1'b1, 6'd0, 1'b0, 8'd0, 1'b0};

  sram_stream_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(4)) dut (
    .clk0(clk0), .rst0(rst0), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .mem_csb0(mem_csb0), .mem_web0(mem_web0),
    .mem_addr0(mem_addr0), .mem_dout0(mem_dout0),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
`ifdef SRAM_STREAM_PERF_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  always #5 clk0 = ~clk0;
  always @(posedge clk0) cyc <= cyc + 1;

  // SRAM port 0: address sampled at the edge, data valid through the next cycle.
  always @(posedge clk0) if (!mem_csb0) mem_dout0 <= mem[mem_addr0];

  always @(negedge clk0) begin
    if (rst0) begin
      hold_chk = 1'b0; issued = 0; accepted = 0;
    end else begin
      if (hold_chk) begin
        checks++;
        if (!(m_valid === 1'b1 && m_data === prev_data && m_last === prev_last)) begin
          failures++;
          $display("FAIL hold_stable cyc=%0d got v=%b d=%h l=%b want v=1 d=%h l=%b",
                   cyc, m_valid, m_data, m_last, prev_data, prev_last);
        end
      end
      if (mem_csb0 === 1'b0) begin
        issued++;
        if (first_csb < 0) first_csb = cyc;
        checks++;
        if (mem_web0 !== 1'b1 || issued - accepted > 4) begin
          failures++;
          $display("FAIL issue_window cyc=%0d web=%b outstanding=%0d want web=1 outstanding<=4",
                   cyc, mem_web0, issued - accepted);
        end
      end
      if (m_valid === 1'b1 && first_vld < 0) first_vld = cyc;
      if (m_valid === 1'b1 && m_ready === 1'b1) begin
        accepted++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_word cyc=%0d got d=%h l=%b want none", cyc, m_data, m_last);
        end else begin
          e = exp_q.pop_front();
          if ({m_last, m_data} !== e) begin
            failures++;
            $display("FAIL stream_word cyc=%0d got l=%b d=%h want l=%b d=%h",
                     cyc, m_last, m_data, e[DW], e[DW-1:0]);
          end
        end
        if (first_hs < 0) first_hs = cyc;
        last_hs = cyc;
      end
      hold_chk  = m_valid && !m_ready;
      prev_data = m_data;
      prev_last = m_last;
    end
  end

  task automatic do_start(input logic [AW-1:0] b, input logic [AW:0] n);
    logic [AW-1:0] a;
    @(posedge clk0); #1;
    start = 1'b1; base_addr = b; len = n;
    for (int i = 0; i < int'(n); i++) begin
      a = b + AW'(i);
      exp_q.push_back({(i == int'(n) - 1), mem[a]});
    end
    @(posedge clk0); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok, output int dcyc);
    ok = 1'b0; dcyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk0);
      if (done === 1'b1) begin
        ok = 1'b1; dcyc = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk0);
    checks++;
    if ({busy, done, mem_csb0, mem_web0, mem_addr0, m_valid, m_data, m_last} !== rst_vec) begin
      failures++;
      $display("FAIL reset_values got %h want %h",
               {busy, done, mem_csb0, mem_web0, mem_addr0, m_valid, m_data, m_last}, rst_vec);
    end
`ifdef SRAM_STREAM_PERF_EN
    checks++;
    if (stall_cnt !== 16'd0) begin
      failures++; $display("FAIL reset_stall got %0d want 0", stall_cnt);
    end
`endif
    @(posedge clk0); #1 rst0 = 1'b0;
  endtask

  task automatic test_basic();
    bit ok; int dcyc;
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i);
    m_ready = 1'b1;
    first_csb = -1; first_vld = -1; first_hs = -1; last_hs = -1;
    do_start(6'd0, 7'd8);
    @(negedge clk0);
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy got %b want 1", busy); end
    wait_done(100, ok, dcyc);
    checks++;
    if (!ok) begin failures++; $display("FAIL basic_done_timeout got none want done"); end
    checks++;
    if (first_vld - first_csb != 2) begin
      failures++; $display("FAIL basic_latency got %0d want 2", first_vld - first_csb);
    end
    checks++;
    if (last_hs - first_hs != 7) begin
      failures++; $display("FAIL basic_throughput got span %0d want 7", last_hs - first_hs);
    end
    checks++;
    if (dcyc != last_hs + 1) begin
      failures++; $display("FAIL basic_done_timing got %0d want %0d", dcyc, last_hs + 1);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL basic_missing got %0d left want 0", exp_q.size());
    end
    exp_q.delete();
    @(negedge clk0);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL basic_done_pulse got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_wrap();
    bit ok; int dcyc;
    m_ready = 1'b1;
    do_start(6'd62, 7'd4);
    wait_done(100, ok, dcyc);
    checks++;
    if (!ok || dcyc != last_hs + 1) begin
      failures++; $display("FAIL wrap_done got ok=%b cyc=%0d want cyc=%0d", ok, dcyc, last_hs + 1);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL wrap_missing got %0d left want 0", exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    bit ok; int dcyc; int stall_exp; int i0;
    ok = 1'b0; dcyc = -1; stall_exp = 0;
    m_ready = 1'b1;
    do_start(6'd0, 7'd8);
    for (int k = 0; k < 200 && !ok; k++) begin
      m_ready = (k % 3 == 0);
      @(negedge clk0);
      if (busy && m_valid && !m_ready) stall_exp++;
      if (done === 1'b1) begin
        ok = 1'b1; dcyc = cyc;
      end else begin
        @(posedge clk0); #1;
      end
    end
    m_ready = 1'b1;
    checks++;
    if (!ok || dcyc != last_hs + 1) begin
      failures++; $display("FAIL bp_done got ok=%b cyc=%0d want cyc=%0d", ok, dcyc, last_hs + 1);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL bp_missing got %0d left want 0", exp_q.size());
    end
    exp_q.delete();
`ifdef SRAM_STREAM_PERF_EN
    checks++;
    if (stall_cnt !== 16'(stall_exp)) begin
      failures++; $display("FAIL bp_stall_cnt got %0d want %0d", stall_cnt, stall_exp);
    end
    repeat (3) @(negedge clk0);
    checks++;
    if (stall_cnt !== 16'(stall_exp)) begin
      failures++; $display("FAIL bp_stall_hold got %0d want %0d", stall_cnt, stall_exp);
    end
`endif
    // Full stall: only FIFO_DEPTH reads may be outstanding.
    i0 = issued;
    m_ready = 1'b0;
    do_start(6'd16, 7'd8);
    repeat (12) @(negedge clk0);
    checks++;
    if (issued - i0 != 4 || m_valid !== 1'b1) begin
      failures++; $display("FAIL bp_window got reads=%0d v=%b want reads=4 v=1", issued - i0, m_valid);
    end
    @(posedge clk0); #1 m_ready = 1'b1;
    wait_done(100, ok, dcyc);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      failures++; $display("FAIL bp_resume got ok=%b left=%0d want ok=1 left=0", ok, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_len0_full();
    bit ok; int dcyc; int i0;
    i0 = issued;
    m_ready = 1'b1;
    do_start(6'd9, 7'd0);
    @(negedge clk0);
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      failures++; $display("FAIL len0_done got done=%b busy=%b want 1 0", done, busy);
    end
    @(negedge clk0);
    checks++;
    if (done !== 1'b0 || issued != i0 || m_valid !== 1'b0) begin
      failures++; $display("FAIL len0_quiet got done=%b reads=%0d v=%b want 0 0 0", done, issued - i0, m_valid);
    end
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i * 7 + 3);
    i0 = issued;
    do_start(6'd5, 7'd64);
    wait_done(400, ok, dcyc);
    checks++;
    if (!ok || exp_q.size() != 0 || issued - i0 != 64) begin
      failures++; $display("FAIL full_len got ok=%b left=%0d reads=%0d want ok=1 left=0 reads=64",
                           ok, exp_q.size(), issued - i0);
    end
    exp_q.delete();
  endtask

  task automatic test_restart_ignored();
    bit ok; int dcyc; int i0;
    i0 = issued;
    m_ready = 1'b1;
    do_start(6'd10, 7'd8);
    repeat (2) @(negedge clk0);
    @(posedge clk0); #1;
    start = 1'b1; base_addr = 6'd40; len = 7'd5;
    @(posedge clk0); #1;
    start = 1'b0;
    wait_done(100, ok, dcyc);
    checks++;
    if (!ok || exp_q.size() != 0 || issued - i0 != 8) begin
      failures++; $display("FAIL restart_ignored got ok=%b left=%0d reads=%0d want ok=1 left=0 reads=8",
                           ok, exp_q.size(), issued - i0);
    end
    exp_q.delete();
    repeat (4) @(negedge clk0);
    checks++;
    if (busy !== 1'b0 || m_valid !== 1'b0) begin
      failures++; $display("FAIL restart_idle got busy=%b v=%b want 0 0", busy, m_valid);
    end
  endtask

  task automatic test_back_to_back();
    bit ok; int dcyc; logic [AW-1:0] a;
    m_ready = 1'b1;
    do_start(6'd0, 7'd3);
    wait_done(100, ok, dcyc);
    // Start issued during the done cycle must be accepted.
    start = 1'b1; base_addr = 6'd30; len = 7'd2;
    for (int i = 0; i < 2; i++) begin
      a = 6'd30 + AW'(i);
      exp_q.push_back({(i == 1), mem[a]});
    end
    @(posedge clk0); #1 start = 1'b0;
    wait_done(100, ok, dcyc);
    checks++;
    if (!ok || exp_q.size() != 0) begin
      failures++; $display("FAIL back_to_back got ok=%b left=%0d want ok=1 left=0", ok, exp_q.size());
    end
    exp_q.delete();
  endtask

  task automatic test_async_reset();
    bit ok; int dcyc;
    m_ready = 1'b0;
    do_start(6'd20, 7'd3);
    repeat (8) @(negedge clk0);
    checks++;
    if (m_valid !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL arst_pre got v=%b busy=%b want 1 1", m_valid, busy);
    end
    #2 rst0 = 1'b1;
    #1;
    checks++;
    if ({busy, done, mem_csb0, mem_web0, mem_addr0, m_valid, m_data, m_last} !== rst_vec) begin
      failures++;
      $display("FAIL arst_values got %h want %h",
               {busy, done, mem_csb0, mem_web0, mem_addr0, m_valid, m_data, m_last}, rst_vec);
    end
`ifdef SRAM_STREAM_PERF_EN
    checks++;
    if (stall_cnt !== 16'd0) begin
      failures++; $display("FAIL arst_stall got %0d want 0", stall_cnt);
    end
`endif
    exp_q.delete();
    repeat (2) @(posedge clk0);
    #1 rst0 = 1'b0;
    m_ready = 1'b1;
    do_start(6'd7, 7'd3);
    wait_done(100, ok, dcyc);
    checks++;
    if (!ok || exp_q.size() != 0 || dcyc != last_hs + 1) begin
      failures++; $display("FAIL arst_restart got ok=%b left=%0d cyc=%0d want ok=1 left=0 cyc=%0d",
                           ok, exp_q.size(), dcyc, last_hs + 1);
    end
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want TB completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_len0_full();
    test_restart_ignored();
    test_back_to_back();
    test_async_reset();
    repeat (3) @(posedge clk0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
